// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with arbitrary depth, count-based
// threshold flags, synchronous flush, sticky error flags and an optional
// registered read port.
module sync_fifo_flex #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int AF_DEPTH = 3,
  parameter int AE_DEPTH = 2,
  parameter int OUT_REG  = 0
) (
  input  logic                         clock_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  output logic                         wr_valid_o,
  input  logic                         rd_en_i,
  output logic                         rd_valid_o,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         rd_data_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         almost_full_o,
  output logic                         empty_o,
  output logic                         almost_empty_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  input  logic                         err_clr_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(DEPTH - AF_DEPTH);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_DEPTH);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic fullFlag;
  logic emptyFlag;
  logic wrValid;
  logic rdValid;

  // Flags come from the registered occupancy only, so they never depend on
  // this cycle's requests.
  assign fullFlag  = (count_q == FULL_CNT);
  assign emptyFlag = (count_q == '0);

  // A full FIFO still takes a write when a read frees a slot in the same
  // cycle; an empty FIFO never forwards a same-cycle write to the reader.
  assign wrValid = wr_en_i & ~flush_i & (~fullFlag | rd_en_i);
  assign rdValid = rd_en_i & ~flush_i & ~emptyFlag;

  assign wr_valid_o     = wrValid;
  assign rd_valid_o     = rdValid;
  assign count_o        = count_q;
  assign full_o         = fullFlag;
  assign empty_o        = emptyFlag;
  assign almost_full_o  = (count_q >= AF_CNT);
  assign almost_empty_o = (count_q <= AE_CNT);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Next-state for pointers, occupancy and the sticky error flags; pointers
  // wrap explicitly so any depth works, and a set beats a same-cycle clear.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = (wr_en_i & ~flush_i & ~wrValid) | (overflow_q & ~err_clr_i);
    underflow_d = (rd_en_i & ~flush_i & emptyFlag) | (underflow_q & ~err_clr_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wrValid) begin
        tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
      end
      if (rdValid) begin
        head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
      end
      case ({wrValid, rdValid})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately left unreset; only accepted writes touch it.
  always_ff @(posedge clock_i) begin
    if (wrValid) begin
      mem_q[tail_q] <= wr_data_i;
    end
  end

  if (OUT_REG != 0) begin : gOutReg
    logic [WIDTH-1:0] rdData_q;
    logic             rdDataValid_q;

    // Registered read port: capture the head entry on an accepted read; data
    // already captured survives a flush in the following cycle.
    always_ff @(posedge clock_i or posedge rst_i) begin
      if (rst_i) begin
        rdData_q      <= '0;
        rdDataValid_q <= 1'b0;
      end else begin
        rdDataValid_q <= rdValid;
        if (rdValid) begin
          rdData_q <= mem_q[head_q];
        end
      end
    end

    assign rd_data_o       = rdData_q;
    assign rd_data_valid_o = rdDataValid_q;
  end else begin : gFwft
    assign rd_data_o       = mem_q[head_q];
    assign rd_data_valid_o = rdValid;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives two FIFO instances with shared directed stimulus
// (A: depth 5, fall-through; B: depth 16, registered read) and checks both
// against a queue-based reference model plus hand-computed expectations.
module tb_sync_fifo_flex;

  logic        clock;
  logic        rst;
  logic        flush;
  logic        wrEn;
  logic [31:0] wrData;
  logic        rdEn;
  logic        errClr;

  logic        aWrValid, aRdValid, aRdDataValid;
  logic [31:0] aRdData;
  logic [2:0]  aCount;
  logic        aFull, aAf, aEmpty, aAe, aOvf, aUnf;

  logic        bWrValid, bRdValid, bRdDataValid;
  logic [31:0] bRdData;
  logic [4:0]  bCount;
  logic        bFull, bAf, bEmpty, bAe, bOvf, bUnf;

  int testsRun;
  int testsFailed;

  logic [31:0] qA[$];
  logic [31:0] qB[$];
  bit          ovfA, unfA, ovfB, unfB;
  bit          expValidB;
  logic [31:0] expDataB;

  sync_fifo_flex #(.DEPTH(5), .WIDTH(32), .AF_DEPTH(1), .AE_DEPTH(1), .OUT_REG(0)) dutA (
    .clock_i(clock), .rst_i(rst), .flush_i(flush),
    .wr_en_i(wrEn), .wr_data_i(wrData), .wr_valid_o(aWrValid),
    .rd_en_i(rdEn), .rd_valid_o(aRdValid), .rd_data_o(aRdData),
    .rd_data_valid_o(aRdDataValid), .count_o(aCount),
    .full_o(aFull), .almost_full_o(aAf), .empty_o(aEmpty), .almost_empty_o(aAe),
    .overflow_o(aOvf), .underflow_o(aUnf), .err_clr_i(errClr)
  );

  sync_fifo_flex #(.DEPTH(16), .WIDTH(32), .AF_DEPTH(3), .AE_DEPTH(2), .OUT_REG(1)) dutB (
    .clock_i(clock), .rst_i(rst), .flush_i(flush),
    .wr_en_i(wrEn), .wr_data_i(wrData), .wr_valid_o(bWrValid),
    .rd_en_i(rdEn), .rd_valid_o(bRdValid), .rd_data_o(bRdData),
    .rd_data_valid_o(bRdDataValid), .count_o(bCount),
    .full_o(bFull), .almost_full_o(bAf), .empty_o(bEmpty), .almost_empty_o(bAe),
    .overflow_o(bOvf), .underflow_o(bUnf), .err_clr_i(errClr)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: every check steps the shared counters.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write acceptance as the FIFO rules define it, from occupancy alone.
  function automatic bit wrAccept(input int depth, input int cnt);
    return wrEn && !flush && (cnt != depth || rdEn);
  endfunction

  function automatic bit rdAccept(input int cnt);
    return rdEn && !flush && (cnt != 0);
  endfunction

  // Reference model: queues advance on each clock, cleared by async reset.
  always @(posedge clock or posedge rst) begin
    bit wa, ra, wb, rb;
    if (rst) begin
      qA.delete();
      qB.delete();
      ovfA = 0; unfA = 0; ovfB = 0; unfB = 0;
      expValidB = 0;
      expDataB = '0;
    end else begin
      wa = wrAccept(5, qA.size());
      ra = rdAccept(qA.size());
      wb = wrAccept(16, qB.size());
      rb = rdAccept(qB.size());
      ovfA = (wrEn && !flush && !wa) || (ovfA && !errClr);
      unfA = (rdEn && !flush && qA.size() == 0) || (unfA && !errClr);
      ovfB = (wrEn && !flush && !wb) || (ovfB && !errClr);
      unfB = (rdEn && !flush && qB.size() == 0) || (unfB && !errClr);
      expValidB = rb;
      if (rb) expDataB = qB[0];
      if (flush) begin
        qA.delete();
        qB.delete();
      end else begin
        if (ra) void'(qA.pop_front());
        if (wa) qA.push_back(wrData);
        if (rb) void'(qB.pop_front());
        if (wb) qB.push_back(wrData);
      end
    end
  end

  // Compare process: mid-cycle, every output of both instances against the model.
  always @(negedge clock) begin
    if (!rst) begin
      checkOutput("aCount", 64'(aCount), 64'(qA.size()));
      checkOutput("aFull", 64'(aFull), 64'(qA.size() == 5));
      checkOutput("aEmpty", 64'(aEmpty), 64'(qA.size() == 0));
      checkOutput("aAlmostFull", 64'(aAf), 64'(qA.size() >= 4));
      checkOutput("aAlmostEmpty", 64'(aAe), 64'(qA.size() <= 1));
      checkOutput("aWrValid", 64'(aWrValid), 64'(wrAccept(5, qA.size())));
      checkOutput("aRdValid", 64'(aRdValid), 64'(rdAccept(qA.size())));
      checkOutput("aRdDataValid", 64'(aRdDataValid), 64'(rdAccept(qA.size())));
      if (rdAccept(qA.size())) checkOutput("aRdData", 64'(aRdData), 64'(qA[0]));
      checkOutput("aOverflow", 64'(aOvf), 64'(ovfA));
      checkOutput("aUnderflow", 64'(aUnf), 64'(unfA));
      checkOutput("bCount", 64'(bCount), 64'(qB.size()));
      checkOutput("bFull", 64'(bFull), 64'(qB.size() == 16));
      checkOutput("bEmpty", 64'(bEmpty), 64'(qB.size() == 0));
      checkOutput("bAlmostFull", 64'(bAf), 64'(qB.size() >= 13));
      checkOutput("bAlmostEmpty", 64'(bAe), 64'(qB.size() <= 2));
      checkOutput("bWrValid", 64'(bWrValid), 64'(wrAccept(16, qB.size())));
      checkOutput("bRdValid", 64'(bRdValid), 64'(rdAccept(qB.size())));
      checkOutput("bRdDataValid", 64'(bRdDataValid), 64'(expValidB));
      if (expValidB) checkOutput("bRdData", 64'(bRdData), 64'(expDataB));
      checkOutput("bOverflow", 64'(bOvf), 64'(ovfB));
      checkOutput("bUnderflow", 64'(bUnf), 64'(unfB));
    end
  end

  // One cycle of stimulus: drive just after the rising edge, return mid-cycle.
  task automatic applyStimulus(input bit w, input logic [31:0] d, input bit r,
                               input bit f, input bit e);
    @(posedge clock);
    #1;
    wrEn = w; wrData = d; rdEn = r; flush = f; errClr = e;
    @(negedge clock);
  endtask

  // Directed scenario sequence with hand-computed expectations.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1; flush = 1'b0; wrEn = 1'b0; wrData = '0; rdEn = 1'b0; errClr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstEmpty", 64'(aEmpty), 64'd1);
    checkOutput("rstAlmostEmpty", 64'(aAe), 64'd1);
    checkOutput("rstFull", 64'(aFull), 64'd0);
    checkOutput("rstAlmostFull", 64'(aAf), 64'd0);
    checkOutput("rstCount", 64'(aCount), 64'd0);
    checkOutput("rstOverflow", 64'(aOvf), 64'd0);
    checkOutput("rstUnderflow", 64'(aUnf), 64'd0);
    checkOutput("rstRdDataValidB", 64'(bRdDataValid), 64'd0);
    checkOutput("rstRdDataB", 64'(bRdData), 64'd0);
    rst = 1'b0;

    // Fill A to full, overflow it, then drain in order.
    for (int i = 1; i <= 5; i++) applyStimulus(1, 32'(i), 0, 0, 0);
    applyStimulus(1, 32'd6, 0, 0, 0);
    checkOutput("fillCountA", 64'(aCount), 64'd5);
    checkOutput("fillFullA", 64'(aFull), 64'd1);
    checkOutput("sixthWrValidA", 64'(aWrValid), 64'd0);
    checkOutput("sixthWrValidB", 64'(bWrValid), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 32'd0, 1, 0, 0);
      if (i == 1) checkOutput("overflowSetA", 64'(aOvf), 64'd1);
      checkOutput("drainDataA", 64'(aRdData), 64'(i));
      if (i >= 2) checkOutput("drainDataB", 64'(bRdData), 64'(i - 1));
    end
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("drainEmptyA", 64'(aEmpty), 64'd1);
    checkOutput("lagValidB", 64'(bRdDataValid), 64'd1);
    checkOutput("lagDataB", 64'(bRdData), 64'd5);
    checkOutput("bCountAfterDrain", 64'(bCount), 64'd1);
    applyStimulus(0, 32'd0, 0, 0, 1);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("overflowClrA", 64'(aOvf), 64'd0);

    // Streaming: A holds 2 entries while a word goes in and out every cycle.
    applyStimulus(1, 32'd100, 0, 0, 0);
    applyStimulus(1, 32'd101, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 32'(200 + i), 1, 0, 0);
      checkOutput("streamCountA", 64'(aCount), 64'd2);
      checkOutput("streamDataA", 64'(aRdData), (i < 2) ? 64'(100 + i) : 64'(198 + i));
    end
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("streamNoOvfA", 64'(aOvf), 64'd0);
    checkOutput("streamNoUnfA", 64'(aUnf), 64'd0);

    // Threshold sweep on B from empty to full.
    applyStimulus(0, 32'd0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 32'(k), 0, 0, 0);
      checkOutput("sweepCountB", 64'(bCount), 64'(k));
      checkOutput("sweepAeB", 64'(bAe), 64'(k <= 2));
      checkOutput("sweepAfB", 64'(bAf), 64'(k >= 13));
    end
    applyStimulus(1, 32'h99, 1, 0, 0);
    checkOutput("fullBothWrB", 64'(bWrValid), 64'd1);
    checkOutput("fullBothRdB", 64'(bRdValid), 64'd1);
    checkOutput("fullFlagB", 64'(bFull), 64'd1);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("fullHoldCountB", 64'(bCount), 64'd16);
    checkOutput("fullHoldFlagB", 64'(bFull), 64'd1);
    checkOutput("fullHoldAfB", 64'(bAf), 64'd1);
    checkOutput("fullHoldAeB", 64'(bAe), 64'd0);

    // Registered read latency on B.
    applyStimulus(0, 32'd0, 0, 1, 1);
    applyStimulus(1, 32'hA5, 0, 0, 0);
    applyStimulus(0, 32'd0, 1, 0, 0);
    checkOutput("regRdValidB", 64'(bRdValid), 64'd1);
    checkOutput("regNotYetB", 64'(bRdDataValid), 64'd0);
    checkOutput("fwftDataA", 64'(aRdData), 64'hA5);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("regValidB", 64'(bRdDataValid), 64'd1);
    checkOutput("regDataB", 64'(bRdData), 64'hA5);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("regValidDropB", 64'(bRdDataValid), 64'd0);

    // Empty with simultaneous write and read: only the write goes in.
    applyStimulus(1, 32'h11, 1, 0, 0);
    checkOutput("noBypassRdA", 64'(aRdValid), 64'd0);
    checkOutput("noBypassWrA", 64'(aWrValid), 64'd1);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("underflowA", 64'(aUnf), 64'd1);
    checkOutput("underflowB", 64'(bUnf), 64'd1);
    checkOutput("noBypassCountA", 64'(aCount), 64'd1);
    applyStimulus(0, 32'd0, 0, 0, 1);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("underflowClrA", 64'(aUnf), 64'd0);

    // Flush at count 3 with a write pending; B's read before it still lands.
    applyStimulus(1, 32'h22, 0, 0, 0);
    applyStimulus(1, 32'h33, 0, 0, 0);
    applyStimulus(1, 32'h44, 0, 0, 0);
    applyStimulus(0, 32'd0, 1, 0, 0);
    checkOutput("preFlushDataA", 64'(aRdData), 64'h11);
    applyStimulus(1, 32'h55, 0, 1, 0);
    checkOutput("flushWrValidA", 64'(aWrValid), 64'd0);
    checkOutput("flushCountA", 64'(aCount), 64'd3);
    checkOutput("flushLateValidB", 64'(bRdDataValid), 64'd1);
    checkOutput("flushLateDataB", 64'(bRdData), 64'h11);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("postFlushCountA", 64'(aCount), 64'd0);
    checkOutput("postFlushEmptyA", 64'(aEmpty), 64'd1);
    checkOutput("postFlushCountB", 64'(bCount), 64'd0);

    // Asynchronous reset in the middle of traffic with A overflowed.
    for (int i = 0; i < 6; i++) applyStimulus(1, 32'(300 + i), 0, 0, 0);
    @(posedge clock);
    #1;
    rst = 1'b1; wrEn = 1'b1; rdEn = 1'b1;
    #1;
    checkOutput("midRstCountA", 64'(aCount), 64'd0);
    checkOutput("midRstEmptyA", 64'(aEmpty), 64'd1);
    checkOutput("midRstFullA", 64'(aFull), 64'd0);
    checkOutput("midRstAfA", 64'(aAf), 64'd0);
    checkOutput("midRstAeA", 64'(aAe), 64'd1);
    checkOutput("midRstOvfA", 64'(aOvf), 64'd0);
    checkOutput("midRstRdValidA", 64'(aRdValid), 64'd0);
    checkOutput("midRstWrValidA", 64'(aWrValid), 64'd1);
    checkOutput("midRstCountB", 64'(bCount), 64'd0);
    @(posedge clock);
    #1;
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
    applyStimulus(1, 32'h77, 0, 0, 0);
    applyStimulus(0, 32'd0, 1, 0, 0);
    checkOutput("afterRstDataA", 64'(aRdData), 64'h77);
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("afterRstDataB", 64'(bRdData), 64'h77);
    applyStimulus(0, 32'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised synchronous FIFO that succeeds the fixed-threshold data FIFO on datapath buffering paths. It adds any-integer depth (not only powers of two), count-based flags with `>=`/`<=` threshold semantics, an occupancy output, an optional registered read port, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer stages in one clock domain.

## Interface
- `DEPTH`, 16: number of entries. Any integer ≥ 2.
- `WIDTH`, 32: data width in bits.
- `AF_DEPTH`, 3: `almost_full` asserts when free entries ≤ `AF_DEPTH`. Range 0..`DEPTH`-1.
- `AE_DEPTH`, 2: `almost_empty` asserts when occupancy ≤ `AE_DEPTH`. Range 0..`DEPTH`-1.
- `OUT_REG`, 0: 0 = first-word-fall-through (`rd_data` is combinational from the head entry); 1 = registered read data, valid one cycle after the accepted read.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-high.
- `flush` in 1: synchronous clear of contents.
- `wr_en` in 1: write request.
- `wr_data` in `WIDTH`: write data.
- `wr_valid` out 1: write accepted this cycle.
- `rd_en` in 1: read request.
- `rd_valid` out 1: read accepted this cycle.
- `rd_data` out `WIDTH`: read data.
- `rd_data_valid` out 1: `rd_data` is valid this cycle.
- `count` out `$clog2(DEPTH+1)`: current occupancy.
- `full`, `almost_full`, `empty`, `almost_empty` out 1: status flags.
- `overflow`, `underflow` out 1: sticky error flags.
- `err_clr` in 1: clears the sticky error flags.

## Operation
- Write acceptance: `wr_valid = wr_en & !flush & (!full | rd_en)`. A write while full is accepted only when a read is accepted in the same cycle.
- Read acceptance: `rd_valid = rd_en & !flush & !empty`. There is no bypass: when the FIFO is empty and `wr_en` and `rd_en` are both high, only the write is accepted.
- Pointers: `head` and `tail` range 0..`DEPTH`-1 and wrap from `DEPTH`-1 to 0.
- Storage: an accepted write stores `wr_data` at `tail`. Storage is not reset.
- Occupancy: next `count` = `count` + `wr_valid` − `rd_valid`. Accepted writes and reads never drive `count` outside 0..`DEPTH`.
- Flags are combinational from the registered `count` only:
  - `full` = (`count` == `DEPTH`)
  - `empty` = (`count` == 0)
  - `almost_full` = (`count` ≥ `DEPTH` − `AF_DEPTH`)
  - `almost_empty` = (`count` ≤ `AE_DEPTH`)
- Error flags:
  - `overflow` sets when `wr_en & !flush & !wr_valid`.
  - `underflow` sets when `rd_en & !flush & empty`.
  - Both clear on `err_clr`. If set and clear occur in the same cycle, set wins.
  - `flush` does not affect either flag.
- Flush: the next state is `head` = `tail` = `count` = 0. Writes and reads in the flush cycle are ignored. Storage is untouched.
- `OUT_REG`=0:
  - `rd_data` = mem[`head`].
  - `rd_data_valid` = `rd_valid`.
- `OUT_REG`=1:
  - On an accepted read, `rd_data` registers mem[`head`] and `rd_data_valid` is 1 in the next cycle.
  - Otherwise `rd_data` holds its value and `rd_data_valid` is 0.
  - A read accepted in the cycle before a flush still delivers its data.
- `rd_data` is meaningful only when `rd_data_valid`=1. Benches do not check it otherwise.

## Timing
- Reset values: pointers and `count` 0; `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (since `AF_DEPTH` < `DEPTH`); `wr_valid`/`rd_valid` follow their inputs; `overflow`=`underflow`=0; `rd_data_valid`=0; `rd_data`=0 when `OUT_REG`=1.
- Write accepted at edge N: `count`, `empty` and the flags update after edge N. The entry is readable in cycle N+1. Minimum write-to-read latency is 1 cycle.
- Read latency: 0 cycles for `OUT_REG`=0, 1 cycle for `OUT_REG`=1.
- Full with simultaneous read and write: both accepted; `count` stays `DEPTH`; `full` stays high.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first accepted write after release lands in entry 0.
- Sustained throughput: 1 write and 1 read per cycle.

## Test plan
- `DEPTH`=5, `OUT_REG`=0: write 1,2,3,4,5 -> `full`=1 and `count`=5 after the 5th edge; a 6th write gives `wr_valid`=0 and `overflow`=1; 5 reads return 1..5 in order, then `empty`=1.
- `DEPTH`=5: stream 12 words with simultaneous writes and reads every cycle -> pointers wrap twice; data is in order; `count` stays constant; no error flags.
- `DEPTH`=16, `AF_DEPTH`=3, `AE_DEPTH`=2: fill from 0 to 16 -> `almost_empty` is high at `count` 0–2; `almost_full` rises at `count`=13 and stays high through 16.
- `OUT_REG`=1: write 0xA5, read next cycle -> `rd_data`=0xA5 with `rd_data_valid`=1 exactly one cycle after `rd_valid`.
- Empty with `wr_en`=`rd_en`=1 -> `rd_valid`=0, `underflow`=1, `count`=1 next cycle. Pulse `err_clr` with `rd_en`=0 -> `underflow`=0.
- At `count`=3, assert `flush` together with `wr_en` -> `wr_valid`=0; next cycle `count`=0 and `empty`=1. Assert `rst` mid-stream -> all flags return to reset values immediately.
